// File: rtl/subframe_readout_scheduler_if.sv
// Handshake and datapath-control bundle for subframe_readout_scheduler.
//   master modport : scheduler side (drives ACKs, addresses and strobes)
//   slave  modport : environment side (drives requests and FIFO back-pressure)
// Signals:
//   FSMIND0/FSMIND1       level readout requests from the two exposure FSMs
//   FIFO_FULL             output FIFO full, stalls sampling
//   FSMIND0ACK/FSMIND1ACK four-phase acknowledges
//   ROW_ADD[7:0]          pixel row address
//   MUX_ADD[5:0]          column-mux address
//   PRECH_COL, CLK_CDS    column precharge and CDS clock
//   ADC_SAMPLE            one-cycle capture/FIFO-write strobe
//   BANK, BUSY            granted bank and transaction-in-progress flag
`timescale 1ns/1ps
interface subframe_readout_scheduler_if;
  logic       FSMIND0;
  logic       FSMIND1;
  logic       FIFO_FULL;
  logic       FSMIND0ACK;
  logic       FSMIND1ACK;
  logic [7:0] ROW_ADD;
  logic [5:0] MUX_ADD;
  logic       PRECH_COL;
  logic       CLK_CDS;
  logic       ADC_SAMPLE;
  logic       BANK;
  logic       BUSY;

  modport master (
    input  FSMIND0, FSMIND1, FIFO_FULL,
    output FSMIND0ACK, FSMIND1ACK, ROW_ADD, MUX_ADD,
           PRECH_COL, CLK_CDS, ADC_SAMPLE, BANK, BUSY
  );

  modport slave (
    output FSMIND0, FSMIND1, FIFO_FULL,
    input  FSMIND0ACK, FSMIND1ACK, ROW_ADD, MUX_ADD,
           PRECH_COL, CLK_CDS, ADC_SAMPLE, BANK, BUSY
  );
endinterface

// File: rtl/subframe_readout_scheduler.sv
// Round-robin arbiter for the two subframe readout requests plus the
// frame sequencer of the shared pixel-readout datapath. Each grant runs one
// full frame: per row a column precharge, one CDS clock, then MUX_CH column
// samples each held SETTLE_CYC clocks, and finally a four-phase ACK to the
// granted requester.
// Ports:
//   CLK_HS  system clock, rising edge
//   RESET   synchronous active-high reset
//   bus     subframe_readout_scheduler_if.master (requests, FIFO_FULL in;
//           ACKs, ROW_ADD, MUX_ADD, PRECH_COL, CLK_CDS, ADC_SAMPLE, BANK,
//           BUSY out)
`timescale 1ns/1ps
module subframe_readout_scheduler #(
  parameter int NUM_ROWS   = 160,
  parameter int MUX_CH     = 64,
  parameter int SETTLE_CYC = 4,
  parameter int PRECH_CYC  = 8
) (
  input  logic                        CLK_HS,
  input  logic                        RESET,
  subframe_readout_scheduler_if.master bus
);

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PRE_W = (PRECH_CYC > 1) ? $clog2(PRECH_CYC) : 1;

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRECH_CYC - 1);
  localparam logic [7:0]       ROW_LAST = 8'(NUM_ROWS - 1);
  localparam logic [5:0]       MUX_LAST = 6'(MUX_CH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRECH = 3'd1,
    CDS   = 3'd2,
    COL   = 3'd3,
    ACK   = 3'd4
  } state_t;

  state_t           state_r;
  logic [SET_W-1:0] set_cnt_r;
  logic [PRE_W-1:0] pre_cnt_r;
  logic [7:0]       row_r;
  logic [5:0]       mux_r;
  logic             prech_r;
  logic             cds_r;
  logic             bank_r;
  logic             busy_r;
  logic             ack0_r;
  logic             ack1_r;
  logic             last_served_r;

  logic             req_any_s;
  logic             winner_s;
  logic             req_cur_s;
  logic             last_settle_s;
  logic             adc_sample_s;

  // Arbitration winner, request of the granted bank, and sample-slot decode.
  always_comb begin
    req_any_s = bus.FSMIND0 | bus.FSMIND1;
    if (bus.FSMIND0 && bus.FSMIND1) begin
      winner_s = ~last_served_r;
    end else begin
      winner_s = bus.FSMIND1;
    end
    req_cur_s     = bank_r ? bus.FSMIND1 : bus.FSMIND0;
    last_settle_s = (state_r == COL) && (set_cnt_r == SET_LAST);
    // The sample slot comes from registered state; qualifying it with the
    // live FIFO_FULL guarantees no strobe is ever issued into a full FIFO
    // while still allowing the pulse on the very first non-full cycle.
    adc_sample_s  = last_settle_s && !bus.FIFO_FULL;
  end

  // Readout sequencer: arbitration, row/column stepping and ACK phase.
  always_ff @(posedge CLK_HS) begin
    if (RESET) begin
      state_r       <= IDLE;
      set_cnt_r     <= '0;
      pre_cnt_r     <= '0;
      row_r         <= 8'd0;
      mux_r         <= 6'd0;
      prech_r       <= 1'b0;
      cds_r         <= 1'b0;
      bank_r        <= 1'b0;
      busy_r        <= 1'b0;
      ack0_r        <= 1'b0;
      ack1_r        <= 1'b0;
      last_served_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_any_s) begin
            bank_r    <= winner_s;
            busy_r    <= 1'b1;
            row_r     <= 8'd0;
            mux_r     <= 6'd0;
            prech_r   <= 1'b1;
            pre_cnt_r <= '0;
            state_r   <= PRECH;
          end
        end
        PRECH: begin
          if (pre_cnt_r == PRE_LAST) begin
            prech_r <= 1'b0;
            cds_r   <= 1'b1;
            state_r <= CDS;
          end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
          end
        end
        CDS: begin
          cds_r     <= 1'b0;
          set_cnt_r <= '0;
          state_r   <= COL;
        end
        COL: begin
          // Only the final settle cycle looks at FIFO_FULL; a full FIFO
          // freezes the column here until the strobe can be issued.
          if (set_cnt_r != SET_LAST) begin
            set_cnt_r <= set_cnt_r + SET_W'(1);
          end else if (!bus.FIFO_FULL) begin
            set_cnt_r <= '0;
            if (mux_r == MUX_LAST) begin
              mux_r <= 6'd0;
              if (row_r == ROW_LAST) begin
                ack0_r  <= ~bank_r;
                ack1_r  <= bank_r;
                state_r <= ACK;
              end else begin
                row_r     <= row_r + 8'd1;
                prech_r   <= 1'b1;
                pre_cnt_r <= '0;
                state_r   <= PRECH;
              end
            end else begin
              mux_r <= mux_r + 6'd1;
            end
          end
        end
        ACK: begin
          // ACK is already high for at least this cycle; release it once the
          // granted request is seen low.
          if (!req_cur_s) begin
            ack0_r        <= 1'b0;
            ack1_r        <= 1'b0;
            busy_r        <= 1'b0;
            last_served_r <= bank_r;
            state_r       <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          set_cnt_r <= '0;
          pre_cnt_r <= '0;
          row_r     <= 8'd0;
          mux_r     <= 6'd0;
          prech_r   <= 1'b0;
          cds_r     <= 1'b0;
          busy_r    <= 1'b0;
          ack0_r    <= 1'b0;
          ack1_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.FSMIND0ACK = ack0_r;
  assign bus.FSMIND1ACK = ack1_r;
  assign bus.ROW_ADD    = row_r;
  assign bus.MUX_ADD    = mux_r;
  assign bus.PRECH_COL  = prech_r;
  assign bus.CLK_CDS    = cds_r;
  assign bus.ADC_SAMPLE = adc_sample_s;
  assign bus.BANK       = bank_r;
  assign bus.BUSY       = busy_r;

endmodule
